// File: rtl/jtcop_pkg.sv
// Shared Data East/Caveman Ninja board definitions: game identifiers, MCU ROM
// fetch types and the Hippodrome ROM byte unscramble.
package jtcop_pkg;

    localparam logic [1:0] HIPPODROME = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PFETCH
    } mcu_rom_state_t;

    typedef struct packed {
        logic        valid;
        logic [14:0] tag;
        logic [15:0] data;
    } rom_entry_t;

    localparam int BUF_CUR = 0;
    localparam int BUF_NXT = 1;

    // Hippodrome ROMs have data bits 7 and 0 exchanged.
    function automatic logic [7:0] hippo_unscramble(input logic [7:0] din);
        return {din[0], din[6:1], din[7]};
    endfunction

    function automatic logic [7:0] rom_byte(input logic [1:0] game_id, input logic [7:0] din);
        return (game_id == HIPPODROME) ? hippo_unscramble(din) : din;
    endfunction

endpackage

// File: rtl/jtcop_mcu_rom_if.sv
// MCU program-fetch bus plus the SDRAM ROM slot it is served from.
interface jtcop_mcu_rom_if;
    logic [15:0] mcu_addr;
    logic        mcu_cs;
    logic [7:0]  mcu_data;
    logic        mcu_ok;
    logic [14:0] rom_addr;
    logic        rom_cs;
    logic [15:0] rom_data;
    logic        rom_ok;

    // slave: the ROM responder; master: MCU plus SDRAM arbiter side
    modport slave (
        input  mcu_addr, mcu_cs, rom_data, rom_ok,
        output mcu_data, mcu_ok, rom_addr, rom_cs
    );

    modport master (
        output mcu_addr, mcu_cs, rom_data, rom_ok,
        input  mcu_data, mcu_ok, rom_addr, rom_cs
    );
endinterface

// File: rtl/jtcop_mcu_rom_buf.sv
// Two-word fetch buffer (current word and sequential prefetch) with tag
// compare, byte select and promotion of the prefetched word.
import jtcop_pkg::*;

module jtcop_mcu_rom_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mcu_cs,
    input  logic [15:0] mcu_addr,
    input  logic        fetch_done,
    input  logic        pf_done,
    input  logic [14:0] wr_tag,
    input  logic [15:0] wr_data,
    output logic        hit,
    output logic [7:0]  hit_byte,
    output logic        cur_valid,
    output logic [14:0] cur_tag,
    output logic        nxt_seq
);

    rom_entry_t  ent_reg [2];
    logic [1:0]  match;
    logic [15:0] hit_word;
    logic        promote;
    logic        pf_keep;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign match[gi] = ent_reg[gi].valid && (ent_reg[gi].tag == mcu_addr[15:1]);
        end
    endgenerate

    assign hit       = mcu_cs && (match != 2'b00);
    assign hit_word  = match[BUF_CUR] ? ent_reg[BUF_CUR].data : ent_reg[BUF_NXT].data;
    assign hit_byte  = mcu_addr[0] ? hit_word[15:8] : hit_word[7:0];
    assign promote   = mcu_cs && match[BUF_NXT] && !match[BUF_CUR];
    assign cur_valid = ent_reg[BUF_CUR].valid;
    assign cur_tag   = ent_reg[BUF_CUR].tag;
    assign nxt_seq   = ent_reg[BUF_NXT].valid &&
                       (ent_reg[BUF_NXT].tag == ent_reg[BUF_CUR].tag + 15'd1);

    // A prefetch landing together with a promotion is only useful if it
    // follows the word that just became current.
    assign pf_keep = !promote || (wr_tag == ent_reg[BUF_NXT].tag + 15'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_reg[BUF_CUR] <= '0;
            ent_reg[BUF_NXT] <= '0;
        end else if (fetch_done) begin
            ent_reg[BUF_CUR]       <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
            ent_reg[BUF_NXT].valid <= 1'b0;
        end else begin
            if (promote) begin
                ent_reg[BUF_CUR]       <= ent_reg[BUF_NXT];
                ent_reg[BUF_NXT].valid <= 1'b0;
            end
            if (pf_done && pf_keep) begin
                ent_reg[BUF_NXT] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
            end
        end
    end

endmodule

// File: rtl/jtcop_mcu_rom.sv
// Protection MCU program-ROM responder: serves byte fetches from the 16-bit
// SDRAM slot through a two-word buffer, with optional sequential prefetch.
import jtcop_pkg::*;

module jtcop_mcu_rom #(
    parameter int PREFETCH = 1,
    parameter int GUARD    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         game_id,
    jtcop_mcu_rom_if.slave     bus
);

    localparam int            GW         = (GUARD > 1) ? $clog2(GUARD + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);

    mcu_rom_state_t state_reg, state_next;
    logic [14:0]    rom_addr_reg, rom_addr_next;
    logic [GW-1:0]  guard_reg, guard_next;
    logic [7:0]     mcu_data_reg;
    logic           mcu_ok_reg;

    logic           hit;
    logic [7:0]     hit_byte;
    logic           cur_valid;
    logic [14:0]    cur_tag;
    logic           nxt_seq;
    logic           fetch_done;
    logic           pf_done;
    logic           demand_miss;
    logic           rom_accept;
    logic [14:0]    demand_tag;

    jtcop_mcu_rom_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .mcu_cs     (bus.mcu_cs),
        .mcu_addr   (bus.mcu_addr),
        .fetch_done (fetch_done),
        .pf_done    (pf_done),
        .wr_tag     (rom_addr_reg),
        .wr_data    (bus.rom_data),
        .hit        (hit),
        .hit_byte   (hit_byte),
        .cur_valid  (cur_valid),
        .cur_tag    (cur_tag),
        .nxt_seq    (nxt_seq)
    );

    assign demand_tag  = bus.mcu_addr[15:1];
    assign demand_miss = bus.mcu_cs && !hit;
    // The guard window masks rom_ok that may still belong to the old address.
    assign rom_accept  = (state_reg != ST_IDLE) && bus.rom_ok && (guard_reg == '0);

    always_comb begin
        state_next    = state_reg;
        rom_addr_next = rom_addr_reg;
        guard_next    = (guard_reg != '0) ? guard_reg - 1'b1 : guard_reg;
        fetch_done    = 1'b0;
        pf_done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (demand_miss) begin
                    state_next    = ST_FETCH;
                    rom_addr_next = demand_tag;
                    guard_next    = GUARD_LOAD;
                end else if (PREFETCH != 0 && cur_valid && !nxt_seq) begin
                    // no prefetch until a current word exists to follow
                    state_next    = ST_PFETCH;
                    rom_addr_next = cur_tag + 15'd1;
                    guard_next    = GUARD_LOAD;
                end
            end
            ST_FETCH: begin
                if (rom_accept) begin
                    fetch_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_PFETCH: begin
                if (rom_accept) begin
                    pf_done    = 1'b1;
                    state_next = ST_IDLE;
                end else if (demand_miss && demand_tag != rom_addr_reg) begin
                    state_next    = ST_FETCH;
                    rom_addr_next = demand_tag;
                    guard_next    = GUARD_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rom_addr_reg <= '0;
            guard_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            rom_addr_reg <= rom_addr_next;
            guard_reg    <= guard_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcu_ok_reg   <= 1'b0;
            mcu_data_reg <= '0;
        end else begin
            mcu_ok_reg <= hit;
            if (hit) begin
                mcu_data_reg <= rom_byte(game_id, hit_byte);
            end
        end
    end

    assign bus.mcu_ok   = mcu_ok_reg;
    assign bus.mcu_data = mcu_data_reg;
    assign bus.rom_addr = rom_addr_reg;
    assign bus.rom_cs   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_jtcop_mcu_rom.sv
// Directed bench for jtcop_mcu_rom: MCU reads go through a scoreboard queue,
// SDRAM requests are logged by the ROM model and compared to expected lists.
module tb_jtcop_mcu_rom;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] game_id = 2'd0;

    jtcop_mcu_rom_if bus ();

    jtcop_mcu_rom #(.PREFETCH(1), .GUARD(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .game_id (game_id),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          last_lat = 0;
    bit          pending = 1'b0;
    exp_t        sb_q[$];
    logic [15:0] req_log[$];
    logic [15:0] exp_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        case (a)
            15'h0000: return 16'h3412;
            15'h0001: return 16'h0181;
            15'h0002: return 16'hBC9A;
            15'h0003: return 16'hF0DE;
            15'h4000: return 16'hA55A;
            15'h7FFF: return 16'hC3B4;
            default:  return {a[7:0] ^ 8'hA5, a[7:0]};
        endcase
    endfunction

    // SDRAM model: logs each request ({rise, word address}); on an address
    // change under rom_cs it answers at once with the previous address's data.
    initial begin
        logic [14:0] last;
        bit          prev_cs;
        int          cnt;
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        last         = '0;
        prev_cs      = 1'b0;
        cnt          = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.rom_cs) begin
                bus.rom_ok = 1'b0;
                cnt        = 0;
            end else if (!prev_cs) begin
                req_log.push_back({1'b1, bus.rom_addr});
                last       = bus.rom_addr;
                cnt        = 0;
                bus.rom_ok = 1'b0;
            end else if (bus.rom_addr != last) begin
                req_log.push_back({1'b0, bus.rom_addr});
                bus.rom_ok   = 1'b1;
                bus.rom_data = rom_word(last);
                last         = bus.rom_addr;
                cnt          = 0;
            end else begin
                cnt++;
                bus.rom_ok   = (cnt >= LAT);
                bus.rom_data = rom_word(bus.rom_addr);
            end
            prev_cs = bus.rom_cs;
        end
    end

    // Monitor: a delivery counts once the output has been registered after issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending && bus.mcu_ok && cyc > issue_cyc) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL read: mcu_data=%h delivered with empty scoreboard", bus.mcu_data);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.mcu_data !== e.data) begin
                        bad++;
                        $display("FAIL read %h: mcu_data=%h required %h", e.addr, bus.mcu_data, e.data);
                    end else begin
                        $display("read %h -> %h (latency %0d)", e.addr, bus.mcu_data, cyc - issue_cyc);
                    end
                end
                last_lat = cyc - issue_cyc;
                pending  = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic check_log(input string name);
        check({name, " count"}, req_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < req_log.size(); i++) begin
            check($sformatf("%s req%0d", name, i), req_log[i], exp_log[i]);
        end
        req_log.delete();
        exp_log.delete();
    endtask

    task automatic mcu_read(input logic [15:0] a, input logic [7:0] d);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        bus.mcu_addr = a;
        bus.mcu_cs   = 1'b1;
        e.addr       = a;
        e.data       = d;
        sb_q.push_back(e);
        issue_cyc = cyc;
        pending   = 1'b1;
        n = 0;
        while (pending && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pending) begin
            total++;
            bad++;
            $display("FAIL read %h: no mcu_ok within 50 cycles, required data %h", a, d);
            pending = 1'b0;
            sb_q.delete();
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.mcu_cs = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n      = 1'b0;
        bus.mcu_cs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mcu_addr = '0;
        bus.mcu_cs   = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset mcu_ok", bus.mcu_ok, 1'b0);
        check("reset mcu_data", bus.mcu_data, 8'h00);
        check("reset rom_cs", bus.rom_cs, 1'b0);
        check("reset rom_addr", bus.rom_addr, 15'h0000);
        rst_n = 1'b1;

        // 1: demand fetch, then CUR hit on the odd byte
        mcu_read(16'h0000, 8'h12);
        mcu_read(16'h0001, 8'h34);
        idle(8);
        exp_log.push_back(16'h8000);
        exp_log.push_back(16'h8001);
        check_log("t1 log");

        // 2: Hippodrome twist applied on output, then switched back off
        @(posedge clk);
        #1;
        game_id = 2'd1;
        mcu_read(16'h0000, 8'h12);
        mcu_read(16'h0002, 8'h81);
        mcu_read(16'h0003, 8'h80);
        idle(2);
        #1;
        game_id = 2'd0;
        mcu_read(16'h0003, 8'h01);
        idle(8);
        req_log.delete();

        // 3: sequential reads, prefetched word served without a stall
        do_reset();
        mcu_read(16'h0000, 8'h12);
        mcu_read(16'h0001, 8'h34);
        repeat (6) @(posedge clk);
        mcu_read(16'h0002, 8'h81);
        check("t3 nxt hit latency", last_lat, 1);
        mcu_read(16'h0003, 8'h01);
        idle(8);
        exp_log.push_back(16'h8000);
        exp_log.push_back(16'h8001);
        exp_log.push_back(16'h8002);
        check_log("t3 log");

        // 4: jump while prefetch pending; stale rom_ok in guard cycle
        do_reset();
        mcu_read(16'h0000, 8'h12);
        mcu_read(16'h8000, 8'h5A);
        idle(8);
        exp_log.push_back(16'h8000);
        exp_log.push_back(16'h8001);
        exp_log.push_back(16'h4000);
        exp_log.push_back(16'hC001);
        check_log("t4 log");

        // 5: prefetch address wraps past the top of the ROM
        do_reset();
        mcu_read(16'hFFFE, 8'hB4);
        idle(8);
        exp_log.push_back(16'hFFFF);
        exp_log.push_back(16'h8000);
        check_log("t5 log");
        mcu_read(16'h0000, 8'h12);
        check("t5 wrap hit latency", last_lat, 1);
        idle(2);

        // 6: asynchronous reset in the middle of a fetch
        do_reset();
        mcu_read(16'h0000, 8'h12);
        idle(8);
        @(posedge clk);
        #1;
        bus.mcu_addr = 16'h0010;
        bus.mcu_cs   = 1'b1;
        @(posedge clk);
        #1;
        check("t6 rom_cs mid fetch", bus.rom_cs, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async rom_cs", bus.rom_cs, 1'b0);
        check("t6 async mcu_ok", bus.mcu_ok, 1'b0);
        check("t6 async rom_addr", bus.rom_addr, 15'h0000);
        bus.mcu_cs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete();
        mcu_read(16'h0002, 8'h81);
        idle(8);
        exp_log.push_back(16'h8001);
        exp_log.push_back(16'h8002);
        check_log("t6 log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
